up_down_counter_param: RTL

//   Parametrised successor to the 8-bit enable/reset up-counter: WIDTH-bit up/down counter

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_prescaler.sv | 46 ++++
 rtl/up_down_counter_param.sv | 139 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_pkg
// Purpose : Shared types and constants for the parametrised up/down counter.
//           dir_e  : counting direction (DIR_DOWN / DIR_UP)
//           mode_e : boundary behaviour (MODE_WRAP / MODE_SAT)
//           DEF_WIDTH : default counter width
// Revision: 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 8;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : counter_prescaler
// Purpose : Counts enabled cycles and emits a one-cycle tick on every
//           PRESCALE-th enabled cycle. Only instantiated when the build
//           defines COUNTER_PRESCALE_EN.
// Ports   : clk   - rising-edge clock
//           rst   - synchronous reset, active-low
//           en    - count enable (prescaler holds while low)
//           clear - synchronous clear of the prescaler (parallel load)
//           tick  - high in the enabled cycle that completes a prescale period
// Revision: 1.0 - initial release
// ============================================================================
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int              c_CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == c_LAST);
    // A clear in the same cycle suppresses the tick so a load never steps.
    assign tick   = en & ~clear & w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            // Restart the period on each tick (the counter steps here).
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : counter_prescaler
`default_nettype wire

// File: rtl/up_down_counter_param.sv
`default_nettype none
// ============================================================================
// Module  : up_down_counter_param
// Purpose : WIDTH-bit up/down counter over the range [0, limit] with parallel
//           load, wrap or saturate at the boundary, a registered one-cycle
//           terminal-count pulse and a sticky overflow flag.
//           Build option COUNTER_PRESCALE_EN: when defined, a step happens
//           only on every PRESCALE-th enabled cycle.
// Ports   : clk      - rising-edge clock
//           rst      - synchronous reset, active-low
//           en       - count enable
//           dir      - 1 = up, 0 = down
//           sat      - 1 = saturate, 0 = wrap
//           limit    - inclusive upper bound of the count range
//           load     - parallel load strobe (overrides en)
//           load_val - value to load (clamped to limit)
//           clr_ovf  - clears the sticky overflow flag
//           count    - current count (registered)
//           tc       - terminal-count pulse (registered)
//           ovf      - sticky boundary-hit flag (registered)
// Revision: 1.0 - initial release
// ============================================================================
module up_down_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Reject illegal configurations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("up_down_counter_param: WIDTH must be >= 2");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("up_down_counter_param: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    dir_e             w_dir;
    mode_e            w_mode;
    logic             w_step;
    logic             w_boundary;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_dir  = dir_e'(dir);
    assign w_mode = mode_e'(sat);

`ifdef COUNTER_PRESCALE_EN
    logic w_tick;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (load),
        .tick  (w_tick)
    );

    assign w_step = en & ~load & w_tick;
`else
    assign w_step = en & ~load;
`endif

    assign w_load_clamped = (load_val > limit) ? limit : load_val;

    // Next count for a step. Every result lies in [0, limit], including the
    // case where limit was lowered below the current count.
    always_comb begin
        w_boundary = 1'b0;
        w_step_val = r_count;
        if (w_dir == DIR_UP) begin
            if (r_count >= limit) begin
                w_boundary = 1'b1;
                w_step_val = (w_mode == MODE_SAT) ? limit : '0;
            end else begin
                w_step_val = r_count + 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                w_boundary = 1'b1;
                w_step_val = (w_mode == MODE_SAT) ? '0 : limit;
            end else if (r_count > limit) begin
                w_step_val = limit;
            end else begin
                w_step_val = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (load) begin
                r_count <= w_load_clamped;
                r_tc    <= 1'b0;
            end else if (w_step) begin
                r_count <= w_step_val;
                r_tc    <= w_boundary;
            end else begin
                r_tc    <= 1'b0;
            end

            // Set has priority over clear when both occur on one edge.
            if (w_step && w_boundary) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : up_down_counter_param
`default_nettype wire
